grf_wb_queue: RTL

- Write-side front end of the general register file: the producer of the file's write port (RW/WD/WE/WPC).
- Accepts register-write requests from two sources:
  - Source A: main pipeline ALU/load result, higher priority.
  - Source B: multi-cycle unit result (mul/div, late load).
- Queues requests in order in a small FIFO and issues at most one registered GRF write per cycle.
- Exports a pending-write scoreboard for hazard/stall logic.

---
 rtl/grf_wb_queue_if.sv | 26 ++
 rtl/grf_wb_queue.sv | 98 +++++++++
 2 files changed

// File: rtl/grf_wb_queue_if.sv
// Register-write request bundle for the GRF write queue.
// Source A is the main pipeline, source B the multi-cycle units.
interface grf_wb_queue_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rw;
  logic [31:0] a_wd;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rw;
  logic [31:0] b_wd;
  logic [31:0] b_pc;

  modport master (
    output a_valid, a_rw, a_wd, a_pc,
    output b_valid, b_rw, b_wd, b_pc,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_rw, a_wd, a_pc,
    input  b_valid, b_rw, b_wd, b_pc,
    output a_ready, b_ready
  );
endinterface

// File: rtl/grf_wb_queue.sv
// GRF write-side queue: two request sources, one registered write
// per cycle, plus a pending-write scoreboard for hazard logic.
module grf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  grf_wb_queue_if.slave   src,
  output logic [4:0]      RW,
  output logic [31:0]     WD,
  output logic            WE,
  output logic [31:0]     WPC,
  output logic [31:0]     pending,
  output logic [PTRW:0]   count
);

  localparam logic [PTRW:0] CAP  = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0] CAP1 = (PTRW+1)'(DEPTH - 1);

  logic [4:0]       rw_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic [PTRW-1:0]  b_slot;
  logic             a_st;
  logic             b_st;
  logic             pop;

  // Readiness looks only at registered occupancy; B yields a slot to A.
  always_comb begin
    src.a_ready = (count < CAP);
    src.b_ready = src.a_valid ? (count < CAP1) : (count < CAP);
  end

  // Accepted requests to $0 complete the handshake but are dropped.
  always_comb begin
    a_st   = src.a_valid && src.a_ready && (src.a_rw != 5'd0);
    b_st   = src.b_valid && src.b_ready && (src.b_rw != 5'd0);
    pop    = (count != '0);
    b_slot = a_st ? tail + PTRW'(1) : tail;
  end

  // Entry payload storage; validity is tracked separately.
  always_ff @(posedge Clk) begin
    if (a_st) begin
      rw_q[tail] <= src.a_rw;
      wd_q[tail] <= src.a_wd;
      pc_q[tail] <= src.a_pc;
    end
    if (b_st) begin
      rw_q[b_slot] <= src.b_rw;
      wd_q[b_slot] <= src.b_wd;
      pc_q[b_slot] <= src.b_pc;
    end
  end

  // Pointers, occupancy, valid bits and the registered write port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      WE    <= 1'b0;
      RW    <= '0;
      WD    <= '0;
      WPC   <= '0;
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PTRW'(1);
        RW        <= rw_q[head];
        WD        <= wd_q[head];
        WPC       <= pc_q[head];
      end
      WE <= pop;
      if (a_st) vld[tail]   <= 1'b1;
      if (b_st) vld[b_slot] <= 1'b1;
      tail  <= tail + PTRW'(a_st) + PTRW'(b_st);
      count <= count + (PTRW+1)'(a_st) + (PTRW+1)'(b_st)
             - (PTRW+1)'(pop);
    end
  end

  // A register is pending while queued or while its write is issuing.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pending[rw_q[i]] = 1'b1;
    end
    if (WE) pending[RW] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule
